// File: rtl/ram_timing_model_if.sv
// ------------------------------------------------------------------
// Module : ram_timing_model_if
// Brief  : memory_control <-> RAM request/response bundle
// Rev    : 1.0  initial release
// ------------------------------------------------------------------
`default_nettype none

interface ram_timing_model_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

`default_nettype wire

// File: rtl/ram_timing_model.sv
// ------------------------------------------------------------------
// Module : ram_timing_model
// Brief  : word RAM with LAT-cycle BUSY latency and request checking
// Rev    : 1.0  initial release
// ------------------------------------------------------------------
`default_nettype none

module ram_timing_model #(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input  logic               CLK,
  input  logic               RST,
  ram_timing_model_if.slave  ram
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [3:0] c_LAT = 4'(LAT);

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt,   w_cnt_nxt;
  logic            r_op,    w_op_nxt;
  logic [AW-1:0]   r_idx,   w_idx_nxt;
  logic [31:0]     r_mem [0:(1<<AW)-1];

  logic            w_req;
  logic            w_legal;
  logic            w_illegal;
  logic            w_changed;
  logic [AW-1:0]   w_idx;

  assign w_idx     = ram.ramaddr[AW+1:2];
  assign w_req     = ram.ramREN | ram.ramWEN;
  assign w_legal   = (ram.ramREN ^ ram.ramWEN) && (ram.ramaddr[1:0] == 2'b00)
                     && (ram.ramaddr[31:AW+2] == '0);
  assign w_illegal = w_req & ~w_legal;
  // op is 1 for write; only meaningful when the request is legal
  assign w_changed = (ram.ramWEN != r_op) || (w_idx != r_idx);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_idx_nxt   = r_idx;
    case (r_state)
      FREE, ERROR: begin
        if (w_legal) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = 4'd1;
          w_op_nxt    = ram.ramWEN;
          w_idx_nxt   = w_idx;
        end else if (w_illegal) begin
          w_state_nxt = ERROR;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = FREE;
          w_cnt_nxt   = 4'd0;
        end
      end
      BUSY: begin
        if (!w_req) begin
          w_state_nxt = FREE;
          w_cnt_nxt   = 4'd0;
        end else if (w_illegal) begin
          w_state_nxt = ERROR;
          w_cnt_nxt   = 4'd0;
        end else if (w_changed) begin
          w_cnt_nxt   = 4'd1;
          w_op_nxt    = ram.ramWEN;
          w_idx_nxt   = w_idx;
        end else if (r_cnt == c_LAT) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = FREE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= FREE;
      r_cnt   <= 4'd0;
      r_op    <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Array is never reset; a write commits only at the edge closing ACCESS
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == ACCESS) && r_op && ram.ramWEN)
      r_mem[r_idx] <= ram.ramstore;
  end

  assign ram.ramstate = r_state;
  assign ram.ramload  = ((r_state == ACCESS) && !r_op) ? r_mem[r_idx] : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_ram_timing_model.sv
// ------------------------------------------------------------------
// Module : tb_ram_timing_model
// Brief  : scoreboard bench for ram_timing_model (LAT=2, AW=10)
// Rev    : 1.0  initial release
// ------------------------------------------------------------------
`default_nettype none

module tb_ram_timing_model;

  localparam logic [1:0] c_F = 2'd0, c_B = 2'd1, c_A = 2'd2, c_E = 2'd3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [31:0] ld;
  } exp_t;

  exp_t q[$];
  exp_t e;

  ram_timing_model_if ram ();

  ram_timing_model #(.LAT(2), .AW(10)) dut (
    .CLK (CLK),
    .RST (RST),
    .ram (ram)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Compare the scoreboard head against the cycle driven at this negedge
  always @(negedge CLK) begin
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, "_state"}, 32'(ram.ramstate), 32'(e.st));
      chk({e.tag, "_load"},  ram.ramload,       e.ld);
    end
  end

  task automatic cyc(input string tag, input bit ren, input bit wen,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] est, input logic [31:0] eld);
    exp_t x;
    @(negedge CLK);
    #1;
    ram.ramREN   = ren;
    ram.ramWEN   = wen;
    ram.ramaddr  = addr;
    ram.ramstore = data;
    x.tag = tag;
    x.st  = est;
    x.ld  = eld;
    q.push_back(x);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    cyc(tag, 0, 1, addr, data, c_F, 0);
    cyc(tag, 0, 1, addr, data, c_B, 0);
    cyc(tag, 0, 1, addr, data, c_B, 0);
    cyc(tag, 0, 1, addr, data, c_A, 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cyc(tag, 1, 0, addr, 0, c_F, 0);
    cyc(tag, 1, 0, addr, 0, c_B, 0);
    cyc(tag, 1, 0, addr, 0, c_B, 0);
    cyc(tag, 1, 0, addr, 0, c_A, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ram.ramREN   = 1'b0;
    ram.ramWEN   = 1'b0;
    ram.ramaddr  = '0;
    ram.ramstore = '0;

    cyc("reset", 0, 0, 32'h0,  32'h0,   c_F, 0);
    cyc("reset_req", 0, 1, 32'h10, 32'h999, c_F, 0);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    ram.ramWEN = 1'b0;

    do_write("wr0",   32'h00, 32'hCAFE0000);
    do_write("wr10",  32'h10, 32'hDEADBEEF);
    do_read ("rd10",  32'h10, 32'hDEADBEEF);
    do_write("wr14",  32'h14, 32'h5555AAAA);
    do_write("wr18",  32'h18, 32'h00000066);
    do_write("wr20",  32'h20, 32'h11111111);

    // Address changes in the second BUSY cycle: count restarts
    cyc("restart", 1, 0, 32'h10, 0, c_F, 0);
    cyc("restart", 1, 0, 32'h10, 0, c_B, 0);
    cyc("restart", 1, 0, 32'h14, 0, c_B, 0);
    cyc("restart", 1, 0, 32'h14, 0, c_B, 0);
    cyc("restart", 1, 0, 32'h14, 0, c_B, 0);
    cyc("restart", 1, 0, 32'h14, 0, c_A, 32'h5555AAAA);

    cyc("both",    1, 1, 32'h10, 0, c_F, 0);
    cyc("err_drop",0, 0, 32'h10, 0, c_E, 0);
    cyc("err_free",1, 0, 32'h10, 0, c_F, 0);
    cyc("err_busy",1, 0, 32'h10, 0, c_B, 0);
    cyc("abort",   0, 0, 32'h10, 0, c_B, 0);
    cyc("both2",   1, 1, 32'h10, 0, c_F, 0);
    cyc("err2busy",1, 0, 32'h10, 0, c_E, 0);
    cyc("abort2",  0, 0, 32'h10, 0, c_B, 0);

    cyc("misalign", 0, 1, 32'h13,   32'h12345678, c_F, 0);
    cyc("misalign", 0, 1, 32'h13,   32'h12345678, c_E, 0);
    cyc("oor",      0, 1, 32'h1000, 32'h87654321, c_E, 0);
    cyc("err_hold", 0, 0, 32'h0,    0,            c_E, 0);
    do_read("rd10_keep", 32'h10, 32'hDEADBEEF);
    do_read("rd0_keep",  32'h00, 32'hCAFE0000);

    // Write request dropped during ACCESS must not commit
    cyc("wdrop", 0, 1, 32'h18, 32'h77, c_F, 0);
    cyc("wdrop", 0, 1, 32'h18, 32'h77, c_B, 0);
    cyc("wdrop", 0, 1, 32'h18, 32'h77, c_B, 0);
    cyc("wdrop", 0, 0, 32'h18, 32'h77, c_A, 0);
    do_read("rd18_keep", 32'h18, 32'h00000066);

    // Async reset in the middle of a BUSY write
    cyc("rstwr", 0, 1, 32'h20, 32'h22222222, c_F, 0);
    cyc("rstwr", 0, 1, 32'h20, 32'h22222222, c_B, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async_state", 32'(ram.ramstate), 32'(c_F));
    chk("rst_async_load",  ram.ramload,       32'h0);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    ram.ramWEN = 1'b0;
    cyc("post_rst", 0, 0, 32'h0, 0, c_F, 0);
    do_read("rd20_keep", 32'h20, 32'h11111111);
    do_read("rd10_retain", 32'h10, 32'hDEADBEEF);

    // Continuously held read repeats F,B,B,A
    for (int i = 0; i < 3; i++) begin
      cyc("held", 1, 0, 32'h14, 0, c_F, 0);
      cyc("held", 1, 0, 32'h14, 0, c_B, 0);
      cyc("held", 1, 0, 32'h14, 0, c_B, 0);
      cyc("held", 1, 0, 32'h14, 0, c_A, 32'h5555AAAA);
    end
    cyc("idle", 0, 0, 32'h0, 0, c_F, 0);

    @(negedge CLK);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
